// File: rtl/control_unit.sv
// Multicycle RV32I controller: main FSM with memory wait states, ALU/funct decode,
// immediate-type decode and branch resolution. Halts on unsupported instructions.
module control_unit #(
  parameter int unsigned STATE_WIDTH = 4,
  parameter bit          BNE_EN      = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             op_code,
  input  logic [2:0]             funct3,
  input  logic [6:0]             funct7,
  input  logic                   Zero,
  output logic                   adr_src,
  output logic                   mem_write,
  output logic                   IR_write,
  output logic                   reg_write,
  output logic                   PC_write,
  output logic [1:0]             result_src,
  output logic [1:0]             alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             imm_src,
  output logic [2:0]             alu_control,
  output logic                   halted,
  output logic                   instr_retired,
  output logic [STATE_WIDTH-1:0] state_dbg
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_FETCH_WAIT = 4'd1,
    S_DECODE     = 4'd2,
    S_MEMADR     = 4'd3,
    S_MEMREAD    = 4'd4,
    S_MEMWAIT    = 4'd5,
    S_MEMWB      = 4'd6,
    S_MEMWRITE   = 4'd7,
    S_EXEC_R     = 4'd8,
    S_EXEC_I     = 4'd9,
    S_JAL        = 4'd10,
    S_ALUWB      = 4'd11,
    S_BRANCH     = 4'd12,
    S_HALT       = 4'd13
  } state_t;

  state_t     state, state_next;
  logic       f3_ok, r_f7_ok, alu_ok, br_ok;
  logic [2:0] funct_alu;

  // Legality of the arithmetic and branch encodings, resolved while in DECODE
  always_comb begin
    f3_ok   = (funct3 == 3'b000) || (funct3 == 3'b010) || (funct3 == 3'b100) ||
              (funct3 == 3'b110) || (funct3 == 3'b111);
    r_f7_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
    alu_ok  = f3_ok && ((op_code != OP_R) || r_f7_ok);
    br_ok   = (funct3 == 3'b000) || ((funct3 == 3'b001) && BNE_EN);
  end

  always_comb begin
    case (funct3)
      3'b000:  funct_alu = (op_code[5] && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b100:  funct_alu = ALU_XOR;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    case (op_code)
      OP_LOAD, OP_I, OP_JALR: imm_src = 2'b00;
      OP_STORE:               imm_src = 2'b01;
      OP_BRANCH:              imm_src = 2'b10;
      OP_JAL:                 imm_src = 2'b11;
      default:                imm_src = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    IR_write      = 1'b0;
    reg_write     = 1'b0;
    PC_write      = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_control   = ALU_ADD;
    halted        = 1'b0;
    instr_retired = 1'b0;
    case (state)
      S_FETCH: state_next = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        IR_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        PC_write   = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op_code)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = alu_ok ? S_EXEC_R : S_HALT;
          OP_I:              state_next = alu_ok ? S_EXEC_I : S_HALT;
          OP_JAL:            state_next = S_JAL;
          OP_BRANCH:         state_next = br_ok ? S_BRANCH : S_HALT;
          default:           state_next = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = op_code[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        state_next = S_MEMWAIT;
      end
      S_MEMWAIT: begin
        adr_src    = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write     = 1'b1;
        instr_retired = 1'b1;
        state_next    = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a   = 2'b10;
        alu_control = funct_alu;
        state_next  = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = funct_alu;
        state_next  = S_ALUWB;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        PC_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_next    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 2'b10;
        alu_control   = ALU_SUB;
        instr_retired = 1'b1;
        // Zero comes from this cycle's rs1-rs2 subtraction
        PC_write      = (funct3 == 3'b000) ? Zero : !Zero;
        state_next    = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_next = S_HALT;
    endcase
  end

  assign state_dbg = STATE_WIDTH'(state);

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multicycle RV32I controller that drives the team's multicycle datapath.
- Consumes op_code/funct3/funct7/Zero from the datapath and produces every datapath select and write enable.
- Main FSM with wait states for the synchronous instruction/data memories, plus an ALU decoder, immediate-type decoder and branch logic.
- Halts on unsupported instructions.

Parameters:
- STATE_WIDTH, 4, width of the state register and state_dbg port.
- BNE_EN, 1, when 1 funct3=001 branches are taken on !Zero; when 0 they are illegal.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- op_code  input  7  instruction[6:0] from IR
- funct3  input  3  instruction[14:12]
- funct7  input  7  instruction[31:25]
- Zero  input  1  ALU zero flag, combinational from the current cycle
- adr_src  output  1  0=PC_current, 1=result
- mem_write  output  1  data memory write enable
- IR_write  output  1  IR and old_PC capture enable
- reg_write  output  1  register file write enable
- PC_write  output  1  PC load enable
- result_src  output  2  00=ALU_out, 01=dmem_data, 10=ALU_result
- alu_src_a  output  2  00=PC_current, 01=old_PC, 10=rs1 flop
- alu_src_b  output  2  00=rs2 flop, 01=imm ext, 10=constant 4
- imm_src  output  2  00=I, 01=S, 10=B, 11=J
- alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- halted  output  1  sticky, set on illegal instruction
- instr_retired  output  1  one-cycle pulse in each instruction's final state
- state_dbg  output  STATE_WIDTH  current state encoding

Behaviour:
- Reset (async, active-high): state=FETCH; halted=0. All outputs take their FETCH values: every write enable 0, adr_src=0, instr_retired=0.
- Outputs are Moore-decoded from state. Exceptions:
  - imm_src is decoded from op_code in all states: lw/I-ALU/jalr-like=00, sw=01, branch=10, jal=11, other=00.
  - PC_write in BRANCH depends on Zero.
- Unlisted outputs in each state are 0. result_src/alu_src default 00.
- States and actions:
  - FETCH: adr_src=0, no writes -> FETCH_WAIT.
  - FETCH_WAIT: adr_src=0, IR_write=1, alu_src_a=00, alu_src_b=10, add, result_src=10, PC_write=1 -> DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01, add (branch/jump target into ALU_out). Next state by op_code:
    - 0000011 -> MEMADR
    - 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1101111 -> JAL
    - 1100011 -> BRANCH
    - other -> HALT
  - MEMADR: alu_src_a=10, alu_src_b=01, add. Goes to MEMREAD if op_code[5]=0, else MEMWRITE.
  - MEMREAD: adr_src=1, result_src=00 -> MEMWAIT.
  - MEMWAIT: adr_src=1, result_src=00 -> MEMWB.
  - MEMWB: result_src=01, reg_write=1, instr_retired=1 -> FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1, instr_retired=1 -> FETCH.
  - EXEC_R: alu_src_a=10, alu_src_b=00, funct-decoded alu_control -> ALUWB.
  - EXEC_I: alu_src_a=10, alu_src_b=01, funct-decoded alu_control -> ALUWB.
  - JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, PC_write=1 -> ALUWB.
  - ALUWB: result_src=00, reg_write=1, instr_retired=1 -> FETCH.
  - BRANCH: alu_src_a=10, alu_src_b=00, sub, result_src=00, instr_retired=1 -> FETCH.
    - PC_write = Zero when funct3=000.
    - PC_write = !Zero when funct3=001 and BNE_EN=1.
  - HALT: all enables 0, halted=1; remains in HALT until reset.
- Funct decode (EXEC_R/EXEC_I):
  - funct3 000: sub if op_code[5]&funct7[5], else add.
  - funct3 010: slt. 100: xor. 110: or. 111: and.
  - Any other funct3, or R-type with funct7 not in {0000000, 0100000}: illegal. Legality is checked in DECODE, which goes to HALT without entering EXEC.
- Illegal branch funct3 (not 000, or 001 with BNE_EN=0): DECODE -> HALT.
- Latencies: R/I/jal 5 cycles, sw 5, branch 4, lw 7 (FETCH to FETCH).
- Reset asserted mid-instruction: immediate return to FETCH. No mem_write/reg_write may be asserted while reset is high.
- mem_write and reg_write are never both 1. IR_write is 1 only in FETCH_WAIT.

Test Plan:
- Reset release, op_code=0110011, funct3=000, funct7=0100000 -> state sequence FETCH, FETCH_WAIT, DECODE, EXEC_R (alu_control=001), ALUWB (reg_write=1, instr_retired=1), FETCH; 5 cycles.
- lw (0000011) -> 7-cycle sequence; adr_src=1 for 2 cycles; reg_write=1 with result_src=01 only in MEMWB; IR_write asserted exactly once.
- sw (0100011) -> MEMWRITE with mem_write=1, imm_src=01, reg_write=0; back in FETCH after 5 cycles.
- Branch: funct3=000 with Zero=1 -> PC_write=1 in BRANCH. Zero=0 -> PC_write=0. funct3=001 with Zero=0 -> PC_write=1.
- jal (1101111) -> DECODE imm_src=11; JAL PC_write=1 with result_src=00; ALUWB reg_write=1.
- Illegal: op_code=1111111 or I-type funct3=001 -> HALT, halted=1, all enables 0 for 20 cycles. Async reset pulse mid-HALT and mid-MEMWAIT -> FETCH, halted=0, no write enable observed during reset.
